// File: rtl/mem_bus_sequencer.sv
// mem_bus_sequencer: multicycle sequencer for the single shared memory bus of
// the RV32I core. Each instruction slot does an optional data access for the
// instruction in EX/MEM, then an instruction fetch. It then pulses pipe_en once
// so that every pipeline register advances together.
// Optional feature macro: BUS_TIMEOUT_EN. When it is defined, a bus access that
// waits TIMEOUT_CYCLES cycles is abandoned and a sticky bus_error is raised.
// When it is undefined, the sequencer waits for bus_ready indefinitely.
module mem_bus_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] NOP_INSTR      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fetch_addr,
  input  logic        mem_valid,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata,
  output logic [31:0] instr_out,
  output logic [31:0] load_data,
  output logic        pipe_en,
  output logic        bus_error
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DATA    = 2'd1,
    FETCH   = 2'd2,
    ADVANCE = 2'd3
  } state_t;

  state_t      state_q;
  logic        bus_req_q;
  logic        bus_we_q;
  logic [31:0] bus_addr_q;
  logic [31:0] bus_wdata_q;
  logic [31:0] instr_q;
  logic [31:0] load_q;
  logic        pipe_en_q;

  // High for one cycle when the outstanding access is abandoned by the timeout.
  logic        abort;

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES <= 256)   ? 8  :
                                  (TIMEOUT_CYCLES <= 65536) ? 16 : 32;
  // Abort happens on the edge that completes the TIMEOUT_CYCLES-th wait cycle.
  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt_q;
  logic             bus_error_q;

  assign abort     = bus_req_q && !bus_ready && (wait_cnt_q == TIMEOUT_LIM);
  assign bus_error = bus_error_q;

  // Count consecutive wait cycles; any completion, abort or idle bus restarts the count.
  always_ff @(posedge clk) begin
    if (!rst || !bus_req_q || bus_ready || abort) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_q + 1'b1;
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus_error_q <= 1'b0;
    end else if (abort) begin
      bus_error_q <= 1'b1;
    end
  end
`else
  // The timeout length is meaningless without the counter; keep it referenced.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign abort              = 1'b0;
  assign bus_error          = 1'b0;
`endif

  // Slot sequencer: registered bus outputs, captured fetch/load data and the advance pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      instr_q     <= '0;
      load_q      <= '0;
      pipe_en_q   <= 1'b0;
    end else begin
      pipe_en_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // mem_valid is looked at only here, so EX/MEM changes mid-slot are harmless.
          bus_req_q <= 1'b1;
          if (mem_valid) begin
            state_q     <= DATA;
            bus_addr_q  <= mem_addr;
            bus_wdata_q <= mem_wdata;
            bus_we_q    <= mem_we;
          end else begin
            state_q    <= FETCH;
            bus_addr_q <= fetch_addr;
            bus_we_q   <= 1'b0;
          end
        end
        DATA: begin
          if (bus_ready || abort) begin
            // A store leaves load_data alone; an aborted load reads as zero.
            if (!bus_we_q) begin
              load_q <= bus_ready ? bus_rdata : '0;
            end
            // fetch_addr is taken now so a PC redirect made during the data access is honoured.
            bus_addr_q <= fetch_addr;
            bus_we_q   <= 1'b0;
            state_q    <= FETCH;
          end
        end
        FETCH: begin
          if (bus_ready || abort) begin
            instr_q   <= bus_ready ? bus_rdata : NOP_INSTR;
            bus_req_q <= 1'b0;
            pipe_en_q <= 1'b1;
            state_q   <= ADVANCE;
          end
        end
        ADVANCE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign instr_out = instr_q;
  assign load_data = load_q;
  assign pipe_en   = pipe_en_q;

endmodule
